pipe_elastic_reg: RTL and testbench

PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_elastic_cell.sv | 41 ++++
 rtl/pipe_elastic_reg.sv | 123 ++++++++++++
 tb/tb_pipe_elastic_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the per-stage record for the elastic pipeline register.
package pipe_pkg;

  localparam int STAGES_MAX  = 4;
  localparam int PAYLOAD_MAX = 256;
  localparam int STALL_W     = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Payload is sized for the widest legal WIDTH; a stage uses the low WIDTH bits.
  typedef struct packed {
    logic                   valid;
    logic [PAYLOAD_MAX-1:0] data;
  } stage_rec_t;

endpackage

// File: rtl/pipe_elastic_cell.sv
// One elastic stage: a valid bit plus payload, loading whenever it is empty or draining.
module pipe_elastic_cell
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  stage_rec_t             rec_q;
  logic [PAYLOAD_MAX-1:0] pad_unused;

  // Bubble collapsing: take a new item when empty or when the held one leaves.
  assign up_ready = !rec_q.valid || dn_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rec_q <= '0;
    end else if (FLUSH) begin
      rec_q.valid <= 1'b0;
    end else if (up_ready) begin
      rec_q.valid <= up_valid;
      if (up_valid) begin
        rec_q.data <= PAYLOAD_MAX'(up_data);
      end
    end
  end

  assign pad_unused = rec_q.data;
  assign valid      = rec_q.valid;
  assign data       = rec_q.data[WIDTH-1:0];

endmodule

// File: rtl/pipe_elastic_reg.sv
// Cascaded elastic pipeline register with flush, occupancy and stall counting.
// Define PIPE_ELASTIC_SKID_EN to place a skid entry ahead of stage 0 (registered IN_READY).
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [2:0]       OCCUPANCY,
  output logic [15:0]      STALL_CNT
);

  // Handshake: an item moves across an interface on a rising CLK edge where both
  // VALID and READY are high; VALID never depends on READY of the same interface.

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pipe_elastic_reg: STAGES out of range");
  end

  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic [2:0]       skid_occ;
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_ready;
  logic [WIDTH-1:0]  stg_data [STAGES];

`ifdef PIPE_ELASTIC_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign IN_READY = !skid_valid;
  // The parked item always feeds stage 0 ahead of anything new.
  assign s0_valid = skid_valid || IN_VALID;
  assign s0_data  = skid_valid ? skid_data : IN_DATA;
  assign skid_occ = {2'b00, skid_valid};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (FLUSH) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (stg_ready[0]) begin
        skid_valid <= 1'b0;
      end
    end else if (IN_VALID && !stg_ready[0]) begin
      skid_valid <= 1'b1;
      skid_data  <= IN_DATA;
    end
  end
`else
  assign IN_READY = stg_ready[0];
  assign s0_valid = IN_VALID;
  assign s0_data  = IN_DATA;
  assign skid_occ = 3'd0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;

    if (k == 0) begin : g_head
      assign up_v = s0_valid;
      assign up_d = s0_data;
    end else begin : g_body
      assign up_v = stg_valid[k-1];
      assign up_d = stg_data[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_r = OUT_READY;
    end else begin : g_link
      assign dn_r = stg_ready[k+1];
    end

    pipe_elastic_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK      (CLK),
      .RESET    (RESET),
      .FLUSH    (FLUSH),
      .up_valid (up_v),
      .up_data  (up_d),
      .up_ready (stg_ready[k]),
      .dn_ready (dn_r),
      .valid    (stg_valid[k]),
      .data     (stg_data[k])
    );
  end

  assign OUT_VALID = stg_valid[STAGES-1];
  assign OUT_DATA  = stg_valid[STAGES-1] ? stg_data[STAGES-1] : '0;

  always_comb begin
    OCCUPANCY = skid_occ;
    for (int i = 0; i < STAGES; i++) begin
      OCCUPANCY = OCCUPANCY + {2'b00, stg_valid[i]};
    end
  end

  logic [STALL_W-1:0] stall_q;

  // Saturating; FLUSH deliberately has no effect here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (OUT_VALID && !OUT_READY && stall_q != STALL_MAX) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed checks plus a short random scoreboard run for pipe_elastic_reg (WIDTH=32, STAGES=2).
module tb_pipe_elastic_reg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
`ifdef PIPE_ELASTIC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             CLK;
  logic             RESET;
  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic [2:0]       OCCUPANCY;
  logic [15:0]      STALL_CNT;

  int vectors    = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_q[$];

  pipe_elastic_reg #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OCCUPANCY (OCCUPANCY),
    .STALL_CNT (STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] exp_d;
    int               occ_m;

    RESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
    do_reset();
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_data",  OUT_DATA,       32'd0);
    chk("rst_occ",       32'(OCCUPANCY), 32'd0);
    chk("rst_in_ready",  32'(IN_READY),  32'd1);
    chk("rst_stall",     32'(STALL_CNT), 32'd0);

    // Stream 0x11,0x22,0x33: visible on output two cycles after each is offered.
    IN_VALID = 1'b1; IN_DATA = 32'h11;
    tick();
    chk("str_c1_valid", 32'(OUT_VALID), 32'd0);
    chk("str_c1_occ",   32'(OCCUPANCY), 32'd1);
    IN_DATA = 32'h22;
    tick();
    chk("str_c2_valid", 32'(OUT_VALID), 32'd1);
    chk("str_c2_data",  OUT_DATA,       32'h11);
    chk("str_c2_occ",   32'(OCCUPANCY), 32'd2);
    IN_DATA = 32'h33;
    tick();
    chk("str_c3_data",  OUT_DATA,       32'h22);
    IN_VALID = 1'b0;
    tick();
    chk("str_c4_data",  OUT_DATA,       32'h33);
    tick();
    chk("str_c5_valid", 32'(OUT_VALID), 32'd0);
    chk("str_c5_occ",   32'(OCCUPANCY), 32'd0);

    // Fill with 0xA0,0xA1 against a stalled output, then stall five cycles.
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 32'hA0;
    tick();
    IN_DATA = 32'hA1;
    tick();
    IN_VALID = 1'b0;
    chk("fill_occ",      32'(OCCUPANCY), 32'd2);
    chk("fill_in_ready", 32'(IN_READY),  SKID ? 32'd1 : 32'd0);
    repeat (5) tick();
    chk("stall_cnt",      32'(STALL_CNT), 32'd5);
    chk("stall_data",     OUT_DATA,       32'hA0);
    chk("stall_valid",    32'(OUT_VALID), 32'd1);
    chk("stall_in_ready", 32'(IN_READY),  SKID ? 32'd1 : 32'd0);

    // Flush with a concurrent offer of 0xBB; the stall cycle still counts.
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'hBB;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("flush_occ",   32'(OCCUPANCY), 32'd0);
    chk("flush_valid", 32'(OUT_VALID), 32'd0);
    chk("flush_data",  OUT_DATA,       32'd0);
    chk("flush_stall", 32'(STALL_CNT), 32'd6);
    OUT_READY = 1'b1;
    tick();
    chk("flush_no_bb_1", 32'(OUT_VALID), 32'd0);
    tick();
    chk("flush_no_bb_2", 32'(OUT_VALID), 32'd0);

    // Reset in the middle of a stall with two items held.
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 32'hC0;
    tick();
    IN_DATA = 32'hC1;
    tick();
    IN_VALID = 1'b0;
    tick();
    chk("pre_rst_occ",   32'(OCCUPANCY), 32'd2);
    chk("pre_rst_stall", 32'(STALL_CNT), 32'd7);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_rst_valid",    32'(OUT_VALID), 32'd0);
    chk("mid_rst_data",     OUT_DATA,       32'd0);
    chk("mid_rst_occ",      32'(OCCUPANCY), 32'd0);
    chk("mid_rst_in_ready", 32'(IN_READY),  32'd1);
    chk("mid_rst_stall",    32'(STALL_CNT), 32'd0);

    // Random handshakes against an in-order scoreboard.
    do_reset();
    occ_m = 0;
    for (int c = 0; c < 3000; c++) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      IN_DATA   = $urandom;
      OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      in_fire  = IN_VALID && IN_READY;
      out_fire = OUT_VALID && OUT_READY;
      if (out_fire) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_extra observed=%h expected=none", OUT_DATA);
        end
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          chk("sb_data", OUT_DATA, exp_d);
        end
      end
      if (in_fire) exp_q.push_back(IN_DATA);
      occ_m = occ_m + int'(in_fire) - int'(out_fire);
      tick();
      chk("sb_occ", 32'(OCCUPANCY), 32'(occ_m));
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          chk("drain_data", OUT_DATA, exp_d);
        end
      end
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_occ",  32'(OCCUPANCY),    32'd0);

    // Long stall to drive the counter into saturation.
    do_reset();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 32'hD0;
    tick();
    IN_DATA = 32'hD1;
    tick();
    IN_VALID = 1'b0;
    repeat (65534) tick();
    chk("sat_fffe", 32'(STALL_CNT), 32'h0000FFFE);
    tick();
    chk("sat_ffff", 32'(STALL_CNT), 32'h0000FFFF);
    repeat (4465) tick();
    chk("sat_hold", 32'(STALL_CNT), 32'h0000FFFF);
    chk("sat_data", OUT_DATA,       32'hD0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
